bcd_alu_seq: RTL
================

# bcd_alu_seq

Parametrised, digit-serial BCD arithmetic unit and successor to the combinational 4-digit BCD ALU. It processes DIGITS packed-BCD digits, one digit per clock, least-significant digit first. It supports add, subtract, nine's complement and compare, with a valid/ready handshake on both input and output. Results stay in packed BCD with an explicit carry/borrow flag, so the block chains into wider BCD datapaths without any binary conversion.

## Interface
- DIGITS, 4, number of BCD digits per operand; must be ≥2. W = 4*DIGITS.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept a command; high only in IDLE.
- op  in  2  0=ADD, 1=SUB, 2=NINES (9's complement of a), 3=CMP.
- a  in  W  packed BCD operand A.
- b  in  W  packed BCD operand B; ignored for NINES.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- c  out  W  packed BCD result, or an error/compare code.
- flag  out  1  ADD carry-out; SUB/CMP borrow (A<B); 0 for NINES and on error.
- err  out  1  an operand digit was >9.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, latch op, a and b; clear the digit index, carry/borrow, nonzero tracker and err; go to RUN.
- RUN: each cycle processes digit i (bits 4i+3:4i), starting at i=0, through the digit unit.
  - ADD: s = a_i + b_i + cin (5 bits). If s>9, digit = s−10 and cout=1; else digit = s and cout=0.
  - SUB/CMP: d = a_i − b_i − bin. If d<0, digit = d+10 and bout=1; else digit = d and bout=0.
  - NINES: digit = 9 − a_i.
  - Any a_i>9 sets sticky err. Any b_i>9 also sets err, except in NINES.
  - A nonzero SUB digit sets the nonzero tracker.
  - After i=DIGITS−1, go to DONE.
- DONE: out_valid=1. When out_ready, go to IDLE.
- Result rules, applied on the RUN→DONE transition:
  - err=1: c = all digits 4'hC; flag=0.
  - ADD/SUB: c = result modulo 10^DIGITS (SUB gives the ten's complement when A<B); flag = final carry/borrow.
  - CMP: A>B gives c=1 (LSD=1, other digits 0). A==B gives c=0. A<B gives c=all ones. flag = final borrow.
  - NINES: c = per-digit 9's complement.
- The full result in c is updated only on entry to DONE; intermediate digits accumulate in an internal shift register.
- Reset values: state=IDLE, c=0, flag=0, err=0, out_valid=0; in_ready=1 after reset deasserts.
- rst in any state aborts the operation with no output. The next cycle is IDLE with outputs at reset values.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..DIGITS. out_valid rises at cycle DIGITS+1.
- Throughput: one command per DIGITS+2 cycles when out_ready is tied high.
- in_valid while not IDLE is ignored; no queueing.
- The out_valid&out_ready edge returns the block to IDLE. The earliest next accept is the following edge; no same-cycle turnaround.
- c, flag and err stay stable for as long as out_valid=1.

## Structure
- Package bcd_alu_pkg:
  - op enum: OP_ADD, OP_SUB, OP_NINES, OP_CMP.
  - state enum: S_IDLE, S_RUN, S_DONE.
  - constants: BCD_ERR_DIGIT = 4'hC, BCD_MAX_DIGIT = 4'd9.
- Sub-module bcd_digit_unit: combinational one-digit add/sub/nines with carry/borrow in and out, plus an invalid-digit output. Instantiated once.
- Top level holds the FSM, the digit counter ($clog2(DIGITS) bits), the operand shift registers and the result shift register.

## Test plan
- rst held 2 cycles, then released → in_ready=1, out_valid=0, c=0, flag=0, err=0.
- DIGITS=4, ADD a=0x1234, b=0x5678, out_ready=1 → c=0x6912, flag=0, out_valid at cycle 5. Then ADD 0x9999+0x0001 → c=0x0000, flag=1.
- SUB 0x0100−0x0200 → c=0x9900, flag=1. NINES a=0x1234 → c=0x8765, flag=0.
- CMP 0x0500 vs 0x0499 → c=0x0001. CMP 0x0499 vs 0x0500 → c=0xFFFF, flag=1. Equal operands → c=0x0000.
- ADD a=0x12A4 → c=0xCCCC, err=1, flag=0. NINES with b=0xFFFF and a valid → err=0.
- out_ready low 3 cycles in DONE → out_valid and c held, in_ready=0. rst pulsed at RUN cycle 2 → IDLE next cycle, no out_valid. DIGITS=8 regression → ADD 0x99999999+0x00000001 → c=0, flag=1 at cycle 9.

Source files
------------

// File: rtl/bcd_alu_pkg.sv
// Shared types and constants for the digit-serial BCD ALU.
// The opcode encoding is the same as the one used by the older combinational ALU.
package bcd_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_NINES = 2'd2,
        OP_CMP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ERR_DIGIT = 4'hC;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_unit.sv
// One BCD digit of add, subtract or nine's complement, with carry/borrow chaining.
// Also flags any operand digit that is not a legal BCD value.
module bcd_digit_unit
    import bcd_alu_pkg::*;
(
    input  op_e        op,
    input  logic [3:0] a_dig,
    input  logic [3:0] b_dig,
    input  logic       cin,
    output logic [3:0] dig,
    output logic       cout,
    output logic       invalid
);

    logic [4:0] sum;
    logic [4:0] diff;

    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        dig  = a_dig;
        cout = 1'b0;
        sum  = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, cin};
        diff = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, cin};
        case (op)
            OP_ADD: begin
                if (sum > 5'd9) begin
                    dig  = sum[3:0] - 4'd10;
                    cout = 1'b1;
                end else begin
                    dig = sum[3:0];
                end
            end
            OP_SUB, OP_CMP: begin
                // diff[4] is the sign of the 5-bit two's-complement difference
                if (diff[4]) begin
                    dig  = diff[3:0] + 4'd10;
                    cout = 1'b1;
                end else begin
                    dig = diff[3:0];
                end
            end
            OP_NINES: dig = BCD_MAX_DIGIT - a_dig;
            default:  dig = a_dig;
        endcase
    end

    assign invalid = (a_dig > BCD_MAX_DIGIT) ||
                     ((op != OP_NINES) && (b_dig > BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_alu_seq.sv
// Digit-serial packed-BCD ALU: one digit per clock, LSD first, valid/ready on both sides.
// Holds the FSM, digit counter, operand shift registers and result assembly.
module bcd_alu_seq
    import bcd_alu_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] c,
    output logic                flag,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

    state_e        state;
    state_e        state_next;
    op_e           op_q;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-5:0]  res_sr;
    logic [CW-1:0] idx;
    logic          carry;
    logic          nz;
    logic          err_acc;

    logic [3:0]    dig;
    logic          dig_cout;
    logic          dig_bad;
    logic [W-1:0]  res_full;
    logic          nz_full;
    logic          err_full;
    logic          last_digit;
    logic [W-1:0]  c_final;
    logic          flag_final;

    bcd_digit_unit u_digit (
        .op      (op_q),
        .a_dig   (a_sr[3:0]),
        .b_dig   (b_sr[3:0]),
        .cin     (carry),
        .dig     (dig),
        .cout    (dig_cout),
        .invalid (dig_bad)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid)   state_next = S_RUN;
            S_RUN:   if (last_digit) state_next = S_DONE;
            S_DONE:  if (out_ready)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    assign last_digit = (idx == LAST_IDX);
    // The current digit lands on top; the previous digits sit below it in res_sr.
    assign res_full   = {dig, res_sr};
    assign nz_full    = nz | (dig != 4'd0);
    assign err_full   = err_acc | dig_bad;

    always_comb begin
        c_final    = res_full;
        flag_final = dig_cout;
        if (err_full) begin
            c_final    = {DIGITS{BCD_ERR_DIGIT}};
            flag_final = 1'b0;
        end else begin
            case (op_q)
                OP_NINES: flag_final = 1'b0;
                OP_CMP: begin
                    if (dig_cout)     c_final = '1;
                    else if (nz_full) c_final = W'(1);
                    else              c_final = '0;
                end
                default: c_final = res_full;
            endcase
        end
    end

    // Control state and visible outputs: reset to a clean, idle block.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_ADD;
            idx     <= '0;
            carry   <= 1'b0;
            nz      <= 1'b0;
            err_acc <= 1'b0;
            c       <= '0;
            flag    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= op_e'(op);
                        idx     <= '0;
                        carry   <= 1'b0;
                        nz      <= 1'b0;
                        err_acc <= 1'b0;
                    end
                end
                S_RUN: begin
                    idx     <= idx + CW'(1);
                    carry   <= dig_cout;
                    nz      <= nz_full;
                    err_acc <= err_full;
                    if (last_digit) begin
                        c    <= c_final;
                        flag <= flag_final;
                        err  <= err_full;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand/result shift registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid) begin
            a_sr <= a;
            b_sr <= b;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 4;
            b_sr   <= b_sr >> 4;
            res_sr <= res_full[W-1:4];
        end
    end

endmodule
